// File: rtl/pc_fetch_unit_if.sv
// ============================================================================
// Module      : pc_fetch_unit_if
// Description : Bundle of control-unit, ALU, memory-handshake and decode
//               signals seen by the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface pc_fetch_unit_if #(
  parameter int PC_WIDTH     = 32,
  parameter int INSTR_WIDTH  = 32,
  parameter int OFFSET_WIDTH = 8
);

  // Next-PC resolution inputs from control_unit and the ALU
  logic [1:0]              branch_control;
  logic                    jump_control;
  logic                    zero;
  logic [OFFSET_WIDTH-1:0] offset;

  // Memory handshakes
  logic                    dmem_busywait;
  logic                    imem_busywait;
  logic [INSTR_WIDTH-1:0]  imem_instr;
  logic                    imem_read;
  logic [PC_WIDTH-1:0]     imem_addr;

  // Decode/execute side
  logic [PC_WIDTH-1:0]     pc;
  logic [INSTR_WIDTH-1:0]  instruction;
  logic                    instr_valid;

  // Fetch-unit side: owns the PC, the imem request and the instruction latch
  modport master (
    input  branch_control,
    input  jump_control,
    input  zero,
    input  offset,
    input  dmem_busywait,
    input  imem_busywait,
    input  imem_instr,
    output imem_read,
    output imem_addr,
    output pc,
    output instruction,
    output instr_valid
  );

  // Environment side: control unit, ALU, memories and decode
  modport slave (
    output branch_control,
    output jump_control,
    output zero,
    output offset,
    output dmem_busywait,
    output imem_busywait,
    output imem_instr,
    input  imem_read,
    input  imem_addr,
    input  pc,
    input  instruction,
    input  instr_valid
  );

endinterface : pc_fetch_unit_if

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// Module      : pc_fetch_unit
// Description : Instruction-fetch stage. Holds the PC, runs the read handshake
//               with instruction memory, presents one instruction per execute
//               slot and resolves the next PC from branch/jump controls and the
//               ALU zero flag. Stalls in the execute slot while data memory is
//               busy.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pc_fetch_unit #(
  parameter int                  PC_WIDTH     = 32,
  parameter int                  INSTR_WIDTH  = 32,
  parameter int                  OFFSET_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_fetch_unit_if.master bus
);

  // Instructions are one word wide, so sequential flow and offsets move in
  // steps of four bytes.
  localparam logic [PC_WIDTH-1:0] c_INSTR_BYTES = PC_WIDTH'(4);
  localparam logic [1:0]          c_BR_BEQ      = 2'b01;
  localparam logic [1:0]          c_BR_BNE      = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [INSTR_WIDTH-1:0] r_instruction;
  logic                   r_instr_valid;
  logic                   r_imem_read;

  logic [PC_WIDTH-1:0]    w_pc_plus4;
  logic [PC_WIDTH-1:0]    w_offset_ext;
  logic [PC_WIDTH-1:0]    w_target;
  logic                   w_take_target;
  logic [PC_WIDTH-1:0]    w_next_pc;

  // Sequential successor and the sign-extended word offset scaled to bytes;
  // both additions wrap silently at the top of the address space.
  assign w_pc_plus4   = r_pc + c_INSTR_BYTES;
  assign w_offset_ext = {{(PC_WIDTH-OFFSET_WIDTH){bus.offset[OFFSET_WIDTH-1]}}, bus.offset};
  assign w_target     = w_pc_plus4 + (w_offset_ext << 2);

  // Redirect decision: jump wins over any branch encoding; 11 is a no-op.
  always_comb begin
    w_take_target = 1'b0;
    if (bus.jump_control) begin
      w_take_target = 1'b1;
    end else if ((bus.branch_control == c_BR_BEQ) && bus.zero) begin
      w_take_target = 1'b1;
    end else if ((bus.branch_control == c_BR_BNE) && !bus.zero) begin
      w_take_target = 1'b1;
    end
    w_next_pc = w_take_target ? w_target : w_pc_plus4;
  end

  // Fetch/execute sequencer; every output is a register so decode sees clean
  // edges, and an asynchronous reset abandons any in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_instruction <= '0;
      r_instr_valid <= 1'b0;
      r_imem_read   <= 1'b0;
    end else begin
      case (r_state)
        // One quiet cycle after reset release, then raise the first request.
        ST_IDLE: begin
          r_imem_read <= 1'b1;
          r_state     <= ST_FETCH;
        end

        // Hold the request until instruction memory stops stalling, then
        // latch the word and hand it to decode.
        ST_FETCH: begin
          if (!bus.imem_busywait) begin
            r_instruction <= bus.imem_instr;
            r_instr_valid <= 1'b1;
            r_imem_read   <= 1'b0;
            r_state       <= ST_EXEC;
          end
        end

        // The instruction stays on the bus while data memory is busy; the
        // branch/jump inputs are only consulted on the edge that leaves.
        ST_EXEC: begin
          if (!bus.dmem_busywait) begin
            r_pc          <= w_next_pc;
            r_instr_valid <= 1'b0;
            r_imem_read   <= 1'b1;
            r_state       <= ST_FETCH;
          end
        end

        default: begin
          r_instr_valid <= 1'b0;
          r_imem_read   <= 1'b0;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

  // The imem address is the PC itself, so a request never targets a stale
  // address.
  assign bus.imem_read   = r_imem_read;
  assign bus.imem_addr   = r_pc;
  assign bus.pc          = r_pc;
  assign bus.instruction = r_instruction;
  assign bus.instr_valid = r_instr_valid;

endmodule : pc_fetch_unit

`default_nettype wire
